// File: rtl/dmem_port_arbiter.sv
// Purpose: shares the single dmem port between the core MEM stage (priority) and a debug/loader port.
// Latency: core access completes in the same cycle; debug is acked one cycle after it is served.
// Backpressure: cpu_stall_o makes the core hold its request; dbg_req_i is held until dbg_ack_o.
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i       core data request; cpu_rdata_o, cpu_stall_o back to core
//   dbg_req_i/we_i/addr_i/wdata_i       debug request; dbg_rdata_o, dbg_ack_o back to requester
//   mem_we_o/addr_o/wdata_o, mem_rdata_i  dmem port (combinational read, write at clock edge)
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_ack_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic {ARB, ACK} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic serve_dbg;
  logic serve_cpu;

  always_comb begin
    serve_dbg   = 1'b0;
    serve_cpu   = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;

    if (state_q == ARB) begin
      // Starved debug request overrides the core's priority for one cycle.
      if (dbg_req_i && (wait_cnt_q == WAIT_MAX)) begin
        serve_dbg = 1'b1;
      end else if (cpu_req_i) begin
        serve_cpu = 1'b1;
      end else if (dbg_req_i) begin
        serve_dbg = 1'b1;
      end

      if (serve_dbg) begin
        state_d    = ACK;
        dbg_ack_d  = 1'b1;
        wait_cnt_d = '0;
        if (!dbg_we_i) begin
          dbg_rdata_d = mem_rdata_i;
        end
      end else if (!dbg_req_i) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      // ACK cycle: the debug request line is stale, so only the core is considered.
      serve_cpu = cpu_req_i;
      state_d   = ARB;
    end
  end

  // Outputs: the address/data mux defaults to the core side when idle.
  assign mem_addr_o  = serve_dbg ? dbg_addr_i  : cpu_addr_i;
  assign mem_wdata_o = serve_dbg ? dbg_wdata_i : cpu_wdata_i;
  assign mem_we_o    = reset_i & (serve_dbg ? dbg_we_i : (serve_cpu & cpu_we_i));
  assign cpu_stall_o = reset_i & serve_dbg & cpu_req_i;
  assign cpu_rdata_o = mem_rdata_i;
  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ARB;
      wait_cnt_q  <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule
